// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and helpers for the UART TX arbiter and its
//            rotate-priority picker.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } arb_state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotate-priority finder. Returns the first set bit
//            of req, searching from ptr upward modulo N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest request wins last
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((32'(ptr) + 32'(k)) % 32'(N));
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART TX serializer between N_REQ byte-stream
//            requesters. Whole messages are granted round-robin, a stalled
//            requester loses its grant after TIMEOUT idle cycles, and GAP
//            idle cycles separate consecutive messages.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024,
  parameter int GAP     = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_valid,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic [N_REQ-1:0]          timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = cnt_width(TIMEOUT);
  localparam int GW = cnt_width(GAP + 1);

  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);
  // With no gap configured a finished message returns straight to IDLE
  localparam arb_state_e    END_STATE = (GAP == 0) ? ST_IDLE : ST_GAP;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0] tout_q, tout_d;

  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              xfer;
  logic [IW-1:0]     next_ptr;
  logic [BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
  end

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign xfer        = tx_valid & tx_ready;
  assign next_ptr    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = tout_q;

  // Zero-latency pass-through of the granted requester while streaming
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state_q == ST_STREAM) begin
      tx_valid           = req_valid[grant_q];
      tx_data            = req_bytes[grant_q];
      req_ready[grant_q] = tx_ready;
    end
  end

  // Grant, completion, stall timeout and inter-message gap sequencing
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    stall_d  = stall_q;
    gap_d    = gap_q;
    tout_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          stall_d = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer && req_last[grant_q]) begin
          // Completion takes precedence over a timeout on the same cycle
          rr_ptr_d = next_ptr;
          gap_d    = GAP_LOAD;
          state_d  = END_STATE;
        end else if (xfer) begin
          stall_d = '0;
        end else if (!req_valid[grant_q]) begin
          if (stall_q == STALL_MAX) begin
            tout_d[grant_q] = 1'b1;
            rr_ptr_d        = next_ptr;
            gap_d           = GAP_LOAD;
            state_d         = END_STATE;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
        // Serializer backpressure with a valid byte holds the counter
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset abandons any message silently
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      stall_q  <= '0;
      gap_q    <= '0;
      tout_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      stall_q  <= stall_d;
      gap_q    <= gap_d;
      tout_q   <= tout_d;
    end
  end

endmodule
`default_nettype wire
